// File: rtl/iic_pkg.sv
// iic_pkg: shared state encoding, bit-phase codes and counter widths for the IIC byte engine
package iic_pkg;
  typedef enum logic [3:0] {
    IDLE, START_A, START_B, START_C, BIT, HOLD, STOP_A, STOP_B, STOP_C
  } state_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam int BCW = 4;
  localparam logic [BCW-1:0] LAST_DATA = BCW'(7);
  localparam logic [BCW-1:0] ACK_BIT = BCW'(8);
endpackage

// File: rtl/iic_phase_tick.sv
// iic_phase_tick: strobes once every CLK_DIV cycles, held at phase start while clr is high
module iic_phase_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/iic_core.sv
// iic_core: single-master I2C byte engine; START/byte/STOP sequencing, shift register and pin drivers
module iic_core
  import iic_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       busy,
  input  logic       start,
  input  logic       stop,
  input  logic       rw,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       sck,
  inout  wire        sda
);
  state_t state, state_n;
  logic [1:0] q, q_n;
  logic [BCW-1:0] bc, bc_n;
  logic [7:0] sr;
  logic rd, tick, sda_low;
  assign busy = state != IDLE && state != HOLD;
  iic_phase_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock(clock), .reset_n(reset_n), .clr(!busy), .tick(tick)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      q <= Q0;
      bc <= '0;
    end else begin
      state <= state_n;
      q <= q_n;
      bc <= bc_n;
    end
  always_comb begin
    state_n = state;
    q_n = q;
    bc_n = bc;
    case (state)
      IDLE: state_n = start ? START_A : IDLE;
      HOLD: begin
        state_n = start ? BIT : stop ? STOP_A : HOLD;
        q_n = Q0;
        bc_n = '0;
      end
      START_A: state_n = tick ? START_B : state;
      START_B: state_n = tick ? START_C : state;
      START_C: begin
        state_n = tick ? BIT : state;
        q_n = Q0;
        bc_n = '0;
      end
      BIT: if (tick) begin
        q_n = q + 1'b1;
        bc_n = q == Q3 ? bc + 1'b1 : bc;
        state_n = (q == Q3 && bc == ACK_BIT) ? HOLD : BIT;
      end
      STOP_A: state_n = tick ? STOP_B : state;
      STOP_B: state_n = tick ? STOP_C : state;
      STOP_C: state_n = tick ? IDLE : state;
      default: state_n = IDLE;
    endcase
  end
  // Write bits leave through sr[7]; read bits enter sr[0] on entry to Q3.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sr <= '0;
      dout <= '0;
      rd <= 1'b0;
    end else if (!busy && start) begin
      sr <= din;
      rd <= rw;
    end else if (state == BIT && tick && bc != ACK_BIT) begin
      if (rd && q == Q2) sr <= {sr[6:0], sda};
      if (!rd && q == Q3) sr <= {sr[6:0], 1'b0};
      if (rd && q == Q3 && bc == LAST_DATA) dout <= sr;
    end
  always_comb begin
    sck = 1'b1;
    sda_low = 1'b0;
    case (state)
      START_B, STOP_B: sda_low = 1'b1;
      START_C, HOLD, STOP_A: begin
        sck = 1'b0;
        sda_low = 1'b1;
      end
      BIT: begin
        sck = q[1];
        sda_low = bc == ACK_BIT ? rd : (!rd && !sr[7]);
      end
      default: ;
    endcase
  end
  assign sda = sda_low ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_iic_core.sv
// tb_iic_core: bus-level checks of iic_core against a transaction model with a behavioural slave
module tb_iic_core;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, rw = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic busy, sck;
  wire sda;
  logic slv_en = 1'b0, seen = 1'b0;
  logic [3:0] k = 4'd0;
  logic [7:0] rb = 8'h00;
  int total = 0, bad = 0, starts = 0, stops = 0;
  logic psck = 1'b1, psda = 1'b1;
  logic bits[$];
  bit owned = 1'b0;
  logic [7:0] mdout = 8'h00;
  pullup (sda);
  assign sda = (slv_en && k < 4'd8 && (seen || !sck) && !rb[3'(4'd7 - k)]) ? 1'b0 : 1'bz;
  iic_core #(.CLK_DIV(1)) dut (
    .clock(clock), .reset_n(reset_n), .busy(busy), .start(start), .stop(stop),
    .rw(rw), .din(din), .dout(dout), .sck(sck), .sda(sda)
  );
  always #5 clock = ~clock;
  // Slave presents bit k while SCL is low and advances on each falling SCL after a rising one.
  always @(posedge sck or negedge slv_en)
    if (!slv_en) seen <= 1'b0;
    else seen <= 1'b1;
  always @(negedge sck or negedge slv_en)
    if (!slv_en) k <= 4'd0;
    else if (seen) k <= k + 4'd1;
  always @(negedge clock) begin
    if (!psck && sck) bits.push_back(sda);
    if (psck && sck && psda && !sda) starts <= starts + 1;
    if (psck && sck && !psda && sda) stops <= stops + 1;
    psck <= sck;
    psda <= sda;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic r, input logic [7:0] d, input bit poke, input bit with_stop);
    int n, s0, p0;
    logic [7:0] old, obs;
    s0 = starts;
    p0 = stops;
    old = mdout;
    bits.delete();
    @(negedge clock);
    start = 1'b1;
    stop = with_stop;
    rw = r;
    din = d;
    rb = d;
    slv_en = r;
    @(negedge clock);
    start = 1'b0;
    stop = 1'b0;
    din = 8'($urandom);
    n = 0;
    while (busy && n < 100) begin
      if (r) chk("dout_no_partial", 32'((dout === old) || (dout === d)), 1);
      start = poke && n == 10;
      n++;
      @(negedge clock);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);
    slv_en = 1'b0;
    chk("busy_len", n, owned ? 36 : 39);
    chk("start_cond", starts - s0, owned ? 0 : 1);
    chk("stop_cond", stops - p0, 0);
    chk("bit_count", bits.size(), 9);
    obs = 8'h00;
    for (int i = 0; i < 8; i++) obs = {obs[6:0], bits.size() > i ? bits[i] : 1'bx};
    chk("data_bits", obs, d);
    chk("ack_bit", bits.size() > 8 ? bits[8] : 1'bx, r ? 0 : 1);
    if (r) mdout = d;
    chk("dout", dout, mdout);
    chk("hold_sck", sck, 0);
    chk("hold_sda", sda, 0);
    chk("hold_busy", busy, 0);
    owned = 1'b1;
  endtask
  task automatic do_stop();
    int n, s0, p0;
    s0 = starts;
    p0 = stops;
    bits.delete();
    @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
    chk("stop_busy_len", n, owned ? 3 : 0);
    chk("stop_cond", stops - p0, owned ? 1 : 0);
    chk("stop_no_start", starts - s0, 0);
    chk("stop_sck_rises", bits.size(), owned ? 1 : 0);
    if (owned) chk("stop_sda_low_at_rise", bits[0], 0);
    chk("idle_sck", sck, 1);
    chk("idle_sda", sda, 1);
    owned = 1'b0;
  endtask
  initial begin
    logic r;
    logic [7:0] d;
    repeat (3) @(negedge clock);
    chk("reset_sck", sck, 1);
    chk("reset_sda", sda, 1);
    chk("reset_busy", busy, 0);
    chk("reset_dout", dout, 0);
    reset_n = 1'b1;
    @(negedge clock);
    xfer(1'b0, 8'hAA, 1'b0, 1'b0);
    xfer(1'b0, 8'h55, 1'b0, 1'b0);
    do_stop();
    do_stop();
    xfer(1'b1, 8'hC3, 1'b0, 1'b0);
    xfer(1'b0, 8'h3C, 1'b1, 1'b0);
    do_stop();
    xfer(1'b0, 8'h96, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      r = 1'($urandom);
      d = 8'($urandom);
      if ($urandom_range(3) == 0) do_stop();
      else xfer(r, d, 1'($urandom), 1'($urandom));
    end
    xfer(1'b1, 8'h5A, 1'b0, 1'b0);
    @(negedge clock);
    start = 1'b1;
    rw = 1'b0;
    din = 8'h0F;
    @(negedge clock);
    start = 1'b0;
    repeat (17) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_sck", sck, 1);
    chk("abort_sda", sda, 1);
    chk("abort_busy", busy, 0);
    chk("abort_dout", dout, 0);
    mdout = 8'h00;
    owned = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    xfer(1'b1, 8'hE7, 1'b0, 1'b0);
    do_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iic_core.md
Name: iic_core

Overview:
- Single-master I2C (IIC) byte engine.
- A host pulses `start` to move one byte on the bus: write `din`, or read into `dout`. A START condition is generated automatically if the bus is not yet owned. A host pulse on `stop` releases the bus with a STOP condition.
- Sits between a CPU peripheral register block and the board-level SCL/SDA pins.

Parameters:
- CLK_DIV, default 1: `clock` cycles per quarter SCL period (one "phase"). Legal range is 1 or more. The SCL bit period is 4*CLK_DIV cycles.

Ports:
- `clock`, input, 1: system clock; all logic rises on its posedge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `busy`, output, 1: high while a START/byte/STOP sequence is in progress.
- `start`, input, 1: one-cycle request to transfer a byte.
- `stop`, input, 1: one-cycle request to issue STOP and release the bus.
- `rw`, input, 1: direction, sampled with `start`. 0 = write `din`, 1 = read into `dout`.
- `din`, input, 8: write data, sampled with `start`, sent MSB first.
- `dout`, output, 8: last byte read, MSB first.
- `sck`, output, 1: SCL, push-pull.
- `sda`, inout, 1: SDA, open-drain. The core drives it to 0 or releases it to Z; an external pull-up is required.

Behaviour:
- Reset (async, `reset_n`=0):
  - state IDLE, `busy`=0, `sck`=1, `sda`=Z, `dout`=8'h00, bus not owned.
  - Reset asserted mid-transfer aborts immediately to these values. No STOP is generated.
- Timing: every state below lasts exactly CLK_DIV cycles, counted by a phase counter.
- Command acceptance:
  - `start`/`stop` are sampled on posedges only while `busy`=0; while `busy`=1 they are ignored (not queued).
  - `busy` rises the cycle after acceptance.
  - `start` and `stop` in the same cycle: `start` wins, `stop` is dropped.
- `start` accepted, bus free: go to START_A (`sck`=1, `sda`=Z), then START_B (`sda`=0, `sck`=1), then START_C (`sck`=0), then the byte.
- `start` accepted, bus owned: go directly to the byte with no repeated START.
- Byte, 8 data bits plus 1 ACK bit. Each bit has four phases:
  - Q0: `sck`=0, `sda` updated.
  - Q1: `sck`=0.
  - Q2: `sck`=1.
  - Q3: `sck`=1. `sda` is sampled on entry to Q3.
- Write (`rw`=0):
  - data bits: `sda`=0 for a 0, Z for a 1, from `din` latched at acceptance.
  - ACK bit: `sda`=Z; the ACK is sampled and discarded.
- Read (`rw`=1):
  - data bits: `sda`=Z; each sample is shifted into a shift register.
  - `dout` updates once, at the end of bit 7. A partial byte is never visible.
  - ACK bit: master drives `sda`=0.
- After the ACK bit: enter HOLD (`sck`=0, `sda`=0), bus owned, `busy`=0.
- `stop` accepted in HOLD:
  - STOP_A (`sck`=0, `sda`=0), then STOP_B (`sck`=1, `sda`=0), then STOP_C (`sda`=Z, `sck`=1), then IDLE.
  - Bus not owned; `busy`=0 on entering IDLE.
- `stop` in IDLE (bus not owned): ignored, `busy` stays 0.
- Latencies with CLK_DIV=1:
  - START + byte: `busy` high for 3+36 = 39 cycles.
  - byte only: 36 cycles.
  - STOP: 3 cycles.
- `sda` changes only while `sck`=0, except inside the START/STOP conditions.

Decomposition:
- Package `iic_pkg` holds:
  - a state enum: IDLE, START_A, START_B, START_C, BIT, HOLD, STOP_A, STOP_B, STOP_C;
  - phase constants Q0–Q3;
  - the bit-count width.
- A single `iic_phase_tick` sub-module generates the CLK_DIV phase strobe.
- The FSM, shift register and pin drivers live in `iic_core`.

Test Plan:
- Reset pulse → `sck`=1, `sda`=Z (pulled 1), `busy`=0, `dout`=00.
- Write 8'hAA with `rw`=0, bus free, CLK_DIV=1:
  - START seen (SDA falls while SCK high);
  - SDA on the 8 SCK rising edges is 1,0,1,0,1,0,1,0;
  - SDA released on the 9th;
  - `busy` high for 39 cycles, then HOLD with `sck`=0.
- In HOLD, `start` with `din`=8'h55:
  - no START condition;
  - SDA bits 0,1,0,1,0,1,0,1;
  - `busy` high for 36 cycles.
- In HOLD, `stop`:
  - SCK rises while SDA=0, then SDA rises while SCK=1;
  - `busy` high 3 cycles; final `sck`=1, `sda`=Z.
- Read, slave model drives 8'hC3:
  - `rw`=1 `start` → `dout`=8'hC3 after bit 7;
  - master drives SDA=0 during the ACK bit.
- `start` pulsed while `busy`=1, and `start`+`stop` together in IDLE:
  - the first is ignored;
  - the second performs only the START+byte, with no STOP.
